alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// ============================================================================
// Module   : alu_ctrl
// Purpose  : Sequencer for an external combinational ALU. It owns a 4-entry
//            register file and runs a fixed IDLE -> EXEC -> DONE handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_rs0,
  input  logic [1:0]    cmd_rs1,
  input  logic [1:0]    cmd_rd,
  input  logic          ld_en,
  input  logic [1:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_in0,
  output logic [DW-1:0] alu_in1,
  output logic [2:0]    alu_operate,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [1:0]    res_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] alu_in0_q;
  logic [DW-1:0] alu_in1_q;
  logic [2:0]    alu_op_q;
  logic [DW-1:0] res_data_q;
  logic [1:0]    res_rd_q;
  logic          res_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      // The writeback below comes later in this block, so it overrides a
      // same-edge load to the same register.
      if (ld_en) regs_q[ld_addr] <= ld_data;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_in0_q <= regs_q[cmd_rs0];
            alu_in1_q <= regs_q[cmd_rs1];
            alu_op_q  <= cmd_op;
            res_rd_q  <= cmd_rd;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          res_data_q       <= alu_out;
          regs_q[res_rd_q] <= alu_out;
          res_valid_q      <= 1'b1;
          state_q          <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;
  assign alu_operate = alu_op_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_valid   = res_valid_q;

endmodule

`default_nettype wire
